// File: rtl/decode_stage_pkg.sv
// Shared decode types for the RV32I(+M) decode stage.
//   Instruction    : raw 32-bit instruction word
//   ALUFuncts      : ALU operation codes; the M-extension codes exist only when
//                    DECODE_RV32M_EN is defined
//   BranchUnitFuncts : compare codes (values equal branch funct3) plus JUMP
//   MicroCode      : decoded control word handed to execute
//   DecodedEntry   : one queue slot {code, pc, illegal}
// Optional feature macro: DECODE_RV32M_EN (multiply/divide decode).
package decode_stage_pkg;

   localparam int unsigned DEC_XLEN = 32;

   typedef logic [31:0] Instruction;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_SLL  = 5'd2,
      ALU_SLT  = 5'd3,
      ALU_SLTU = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_OR   = 5'd8,
      ALU_AND  = 5'd9
`ifdef DECODE_RV32M_EN
      ,
      ALU_MUL    = 5'd10,
      ALU_MULH   = 5'd11,
      ALU_MULHSU = 5'd12,
      ALU_MULHU  = 5'd13,
      ALU_DIV    = 5'd14,
      ALU_DIVU   = 5'd15,
      ALU_REM    = 5'd16,
      ALU_REMU   = 5'd17
`endif
   } ALUFuncts;

   // Conditional codes reuse the branch funct3 value; 010 is free there and
   // marks the unconditional JAL/JALR jump.
   typedef enum logic [2:0] {
      BR_EQ   = 3'b000,
      BR_NE   = 3'b001,
      BR_JUMP = 3'b010,
      BR_LT   = 3'b100,
      BR_GE   = 3'b101,
      BR_LTU  = 3'b110,
      BR_GEU  = 3'b111
   } BranchUnitFuncts;

   typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} Op1Sel;
   typedef enum logic       {OP2_RS2, OP2_IMM}          Op2Sel;
   typedef enum logic [1:0] {RD_ALU, RD_MEM, RD_PC4}    RdSrc;

   typedef struct packed {
      logic     en;
      ALUFuncts funct;
      Op1Sel    op1;
      Op2Sel    op2;
   } AluCode;

   typedef struct packed {
      logic            en;
      BranchUnitFuncts funct;
   } BranchCode;

   typedef struct packed {
      logic       en;
      logic       store;
      logic [2:0] funct3;   // access size / unsigned load
   } LsuCode;

   typedef struct packed {
      AluCode                alu;
      BranchCode             branch;
      LsuCode                lsu;
      logic [4:0]            rs1_addr;
      logic [4:0]            rs2_addr;
      logic [4:0]            rd_addr;
      logic                  rd_en;
      RdSrc                  rd_src;
      logic [DEC_XLEN-1:0]   imm_data;
   } MicroCode;

   typedef struct packed {
      MicroCode              code;
      logic [DEC_XLEN-1:0]   pc;
      logic                  illegal;
   } DecodedEntry;

   // funct3 -> ALU op for the funct7=0000000 register/immediate forms.
   function automatic ALUFuncts base_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

`ifdef DECODE_RV32M_EN
   function automatic ALUFuncts mext_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_MUL;
         3'b001:  return ALU_MULH;
         3'b010:  return ALU_MULHSU;
         3'b011:  return ALU_MULHU;
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         default: return ALU_REMU;
      endcase
   endfunction
`endif

endpackage

// File: rtl/decode_stage_core.sv
// decoder_core: purely combinational RV32I(+M) instruction decoder.
//   inst_i    : raw instruction
//   code_o    : decoded MicroCode (all zero for an illegal encoding)
//   illegal_o : encoding is not a supported instruction
// Optional feature macro: DECODE_RV32M_EN (OP funct7=0000001 decodes MUL..REMU).
module decoder_core
   import decode_stage_pkg::*;
(
   input  Instruction inst_i,
   output MicroCode   code_o,
   output logic       illegal_o
);

   logic [6:0]          opc, f7;
   logic [2:0]          f3;
   logic [4:0]          rd;
   logic [DEC_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   MicroCode            code;
   logic                ill, wr;

   assign opc = inst_i[6:0];
   assign rd  = inst_i[11:7];
   assign f3  = inst_i[14:12];
   assign f7  = inst_i[31:25];

   assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u  = {inst_i[31:12], 12'b0};
   assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
   assign imm_sh = {27'b0, inst_i[24:20]};

   always_comb begin
      code           = '0;
      ill            = 1'b0;
      wr             = 1'b0;
      code.rs1_addr  = inst_i[19:15];
      code.rs2_addr  = inst_i[24:20];
      code.rd_addr   = rd;
      code.alu.funct = ALU_ADD;
      code.alu.op1   = OP1_RS1;
      code.alu.op2   = OP2_IMM;
      code.rd_src    = RD_ALU;
      case (opc)
         OPC_LUI: begin
            code.alu.en   = 1'b1;
            code.alu.op1  = OP1_ZERO;
            code.imm_data = imm_u;
            wr            = 1'b1;
         end
         OPC_AUIPC: begin
            code.alu.en   = 1'b1;
            code.alu.op1  = OP1_PC;
            code.imm_data = imm_u;
            wr            = 1'b1;
         end
         // Jumps: ALU forms the target, rd receives pc+4.
         OPC_JAL: begin
            code.alu.en       = 1'b1;
            code.alu.op1      = OP1_PC;
            code.imm_data     = imm_j;
            code.branch.en    = 1'b1;
            code.branch.funct = BR_JUMP;
            code.rd_src       = RD_PC4;
            wr                = 1'b1;
         end
         OPC_JALR: begin
            ill               = (f3 != 3'b000);
            code.alu.en       = 1'b1;
            code.imm_data     = imm_i;
            code.branch.en    = 1'b1;
            code.branch.funct = BR_JUMP;
            code.rd_src       = RD_PC4;
            wr                = 1'b1;
         end
         OPC_BRANCH: begin
            ill               = (f3 == 3'b010) || (f3 == 3'b011);
            code.alu.en       = 1'b1;
            code.alu.op1      = OP1_PC;
            code.imm_data     = imm_b;
            code.branch.en    = 1'b1;
            code.branch.funct = BranchUnitFuncts'(f3);
         end
         OPC_LOAD: begin
            ill             = (f3 == 3'b011) || (f3 >= 3'b110);
            code.alu.en     = 1'b1;
            code.imm_data   = imm_i;
            code.lsu.en     = 1'b1;
            code.lsu.funct3 = f3;
            code.rd_src     = RD_MEM;
            wr              = 1'b1;
         end
         OPC_STORE: begin
            ill             = (f3 >= 3'b011);
            code.alu.en     = 1'b1;
            code.imm_data   = imm_s;
            code.lsu.en     = 1'b1;
            code.lsu.store  = 1'b1;
            code.lsu.funct3 = f3;
         end
         OPC_OPIMM: begin
            code.alu.en    = 1'b1;
            code.alu.funct = base_alu(f3);
            code.imm_data  = imm_i;
            wr             = 1'b1;
            // Shifts carry a 5-bit shamt; imm[11:5] selects logical/arith.
            if (f3 == 3'b001) begin
               code.imm_data = imm_sh;
               ill           = (f7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               code.imm_data = imm_sh;
               if (f7 == 7'b0100000) code.alu.funct = ALU_SRA;
               else                  ill = (f7 != 7'b0000000);
            end
         end
         OPC_OP: begin
            code.alu.en  = 1'b1;
            code.alu.op2 = OP2_RS2;
            wr           = 1'b1;
            case (f7)
               7'b0000000: code.alu.funct = base_alu(f3);
               7'b0100000: begin
                  if (f3 == 3'b000)      code.alu.funct = ALU_SUB;
                  else if (f3 == 3'b101) code.alu.funct = ALU_SRA;
                  else                   ill = 1'b1;
               end
`ifdef DECODE_RV32M_EN
               7'b0000001: code.alu.funct = mext_alu(f3);
`endif
               default:    ill = 1'b1;
            endcase
         end
         OPC_MISCMEM: ; // FENCE: accepted, nothing to do in an in-order core
         default:     ill = 1'b1;
      endcase
      if (inst_i[1:0] != 2'b11) ill = 1'b1;
      if (ill) code = '0;
      code.rd_en = wr & ~ill & (rd != 5'd0);
   end

   assign code_o    = code;
   assign illegal_o = ill;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, back-pressured RV32I(+M) decode stage.
//   clk, rst (sync, active high), flush
//   in_valid/in_ready/in_inst/in_pc   : fetch side
//   out_valid/out_ready/out_code/out_pc/out_illegal : execute side (head entry)
//   occupancy : number of queued entries
// Decoding happens before the queue; entries are stored already decoded.
// Optional feature macro: DECODE_RV32M_EN (see decoder_core).
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN      = DEC_XLEN,  // must equal DEC_XLEN
   parameter int unsigned BUF_DEPTH = 2          // power of two, >= 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_inst,
   input  logic [XLEN-1:0]              in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output MicroCode                     out_code,
   output logic [XLEN-1:0]              out_pc,
   output logic                         out_illegal,
   output logic [$clog2(BUF_DEPTH):0]   occupancy
);

   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = PW + 1;

   DecodedEntry       mem_q [BUF_DEPTH];
   DecodedEntry       new_entry, head;
   MicroCode          dec_code;
   logic              dec_ill;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              push, pop;

   decoder_core u_core (
      .inst_i    (in_inst),
      .code_o    (dec_code),
      .illegal_o (dec_ill)
   );

   always_comb begin
      new_entry.code    = dec_code;
      new_entry.pc      = in_pc;
      new_entry.illegal = dec_ill;
   end

   // in_ready depends only on occupancy, never on out_ready.
   assign in_ready  = (cnt_q != CW'(BUF_DEPTH));
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage needs no reset; outputs are qualified by out_valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= new_entry;
   end

   assign head        = mem_q[rd_ptr_q];
   assign out_code    = out_valid ? head.code : '0;
   assign out_pc      = head.pc;
   assign out_illegal = out_valid & head.illegal;
   assign occupancy   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
   import decode_stage_pkg::*;

   localparam int DEPTH = 2;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_inst, in_pc, out_pc;
   logic [1:0]  occupancy;
   MicroCode    out_code;

   int n_checks = 0;
   int n_errors = 0;

   decode_stage #(.XLEN(32), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_pc(out_pc), .out_illegal(out_illegal), .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic            ill, alu_en, lsu_en, lsu_st, br_en, rd_en, imm_chk;
      ALUFuncts        fn;
      BranchUnitFuncts bf;
      logic [31:0]     imm;
   } ref_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];

   localparam ALUFuncts BASE_TBL [8] =
      '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
   localparam BranchUnitFuncts BR_TBL [8] =
      '{BR_EQ, BR_NE, BR_JUMP, BR_JUMP, BR_LT, BR_GE, BR_LTU, BR_GEU};
`ifdef DECODE_RV32M_EN
   localparam ALUFuncts M_TBL [8] =
      '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
`endif

   // Immediates computed as weighted bit sums with a negative sign weight.
   function automatic ref_t ref_decode(input logic [31:0] ins);
      ref_t r;
      logic wr;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [31:0] u;
      r  = '0;
      wr = 1'b0;
      f3 = ins[14:12];
      f7 = ins[31:25];
      case (ins[6:0])
         7'h37, 7'h17: begin
            r.alu_en = 1; r.fn = ALU_ADD; r.imm = ins & 32'hFFFFF000; r.imm_chk = 1; wr = 1;
         end
         7'h6F: begin
            u = 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
            if (ins[31]) u = u - 32'h100000;
            r.alu_en = 1; r.fn = ALU_ADD; r.br_en = 1; r.bf = BR_JUMP;
            r.imm = u; r.imm_chk = 1; wr = 1;
         end
         7'h67: begin
            u = 32'(ins[31:20]); if (ins[31]) u = u - 4096;
            r.ill = (f3 != 0);
            r.alu_en = 1; r.fn = ALU_ADD; r.br_en = 1; r.bf = BR_JUMP;
            r.imm = u; r.imm_chk = 1; wr = 1;
         end
         7'h63: begin
            u = 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
            if (ins[31]) u = u - 4096;
            r.ill = (f3 == 2 || f3 == 3);
            r.alu_en = 1; r.fn = ALU_ADD; r.br_en = 1; r.bf = BR_TBL[f3];
            r.imm = u; r.imm_chk = 1;
         end
         7'h03: begin
            u = 32'(ins[31:20]); if (ins[31]) u = u - 4096;
            r.ill = (f3 == 3 || f3 == 6 || f3 == 7);
            r.alu_en = 1; r.fn = ALU_ADD; r.lsu_en = 1; r.imm = u; r.imm_chk = 1; wr = 1;
         end
         7'h23: begin
            u = 32'(ins[31:25]) * 32 + 32'(ins[11:7]); if (ins[31]) u = u - 4096;
            r.ill = (f3 >= 3);
            r.alu_en = 1; r.fn = ALU_ADD; r.lsu_en = 1; r.lsu_st = 1; r.imm = u; r.imm_chk = 1;
         end
         7'h13: begin
            r.alu_en = 1; r.imm_chk = 1; wr = 1;
            if (f3 == 1 || f3 == 5) begin
               r.imm = 32'(ins[24:20]);
               if (f7 == 7'h00)                r.fn = BASE_TBL[f3];
               else if (f7 == 7'h20 && f3 == 5) r.fn = ALU_SRA;
               else                            r.ill = 1;
            end else begin
               u = 32'(ins[31:20]); if (ins[31]) u = u - 4096;
               r.imm = u; r.fn = BASE_TBL[f3];
            end
         end
         7'h33: begin
            r.alu_en = 1; wr = 1;
            if (f7 == 7'h00)                  r.fn = BASE_TBL[f3];
            else if (f7 == 7'h20 && f3 == 0)  r.fn = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 5)  r.fn = ALU_SRA;
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'h01)             r.fn = M_TBL[f3];
`endif
            else                              r.ill = 1;
         end
         7'h0F: ;
         default: r.ill = 1;
      endcase
      if (ins[1:0] != 2'b11) r.ill = 1;
      r.rd_en = wr && (ins[11:7] != 0);
      if (r.ill) begin
         r = '0;
         r.ill = 1;
      end
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_head();
      ref_t r;
      r = ref_decode(mq[0].inst);
      chk("head_pc", out_pc, mq[0].pc);
      chk("head_illegal", out_illegal, r.ill);
      chk("head_alu_en", out_code.alu.en, r.alu_en);
      chk("head_lsu_en", out_code.lsu.en, r.lsu_en);
      chk("head_br_en", out_code.branch.en, r.br_en);
      chk("head_rd_en", out_code.rd_en, r.rd_en);
      if (r.alu_en) chk("head_alu_funct", out_code.alu.funct, r.fn);
      if (r.rd_en)  chk("head_rd_addr", out_code.rd_addr, mq[0].inst[11:7]);
      if (r.imm_chk && !r.ill) chk("head_imm", out_code.imm_data, r.imm);
      if (r.lsu_en) chk("head_lsu_store", out_code.lsu.store, r.lsu_st);
      if (r.br_en)  chk("head_br_funct", out_code.branch.funct, r.bf);
   endtask

   task automatic check_all();
      chk("occupancy", occupancy, mq.size());
      chk("in_ready", in_ready, mq.size() != DEPTH);
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check_head();
   endtask

   // Drive one cycle of inputs, check pre-edge outputs, advance model at the edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
      bit   push, pop;
      ent_t e;
      in_valid = v; in_inst = ins; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
      check_all();
      push = v && (mq.size() < DEPTH) && !fl;
      pop  = (mq.size() != 0) && ordy;
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.inst = ins; e.pc = pc;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] ins;
      int k;
      ins = $urandom;
      k   = $urandom_range(0, 11);
      case (k)
         0: ins[6:0] = 7'h37;
         1: ins[6:0] = 7'h17;
         2: ins[6:0] = 7'h6F;
         3: begin ins[6:0] = 7'h67; if ($urandom_range(0, 1) == 1) ins[14:12] = 3'b000; end
         4: ins[6:0] = 7'h63;
         5: ins[6:0] = 7'h03;
         6: ins[6:0] = 7'h23;
         7: ins[6:0] = 7'h13;
         8: ins[6:0] = 7'h33;
         9: ins[6:0] = 7'h0F;
         10: ;
         default: ins[1:0] = 2'($urandom_range(0, 2));
      endcase
      if (k == 7 || k == 8) begin
         case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h01;
            default: ;
         endcase
      end
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      return ins;
   endfunction

   task automatic probe(input logic [31:0] ins);
      step(1'b1, ins, 32'h300, 1'b0, 1'b0);
   endtask

   task automatic drain();
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'h0; in_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_occupancy", occupancy, 2'd0);
      chk("rst_out_illegal", out_illegal, 1'b0);
      chk("rst_code_en", {out_code.alu.en, out_code.lsu.en, out_code.branch.en, out_code.rd_en}, 4'b0);
      @(posedge clk); #1;

      // addi x1,x0,5 at 0x100
      step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
      chk("addi_valid", out_valid, 1'b1);
      chk("addi_funct", out_code.alu.funct, ALU_ADD);
      chk("addi_imm", out_code.imm_data, 32'd5);
      chk("addi_rd_addr", out_code.rd_addr, 5'd1);
      chk("addi_rd_en", out_code.rd_en, 1'b1);
      chk("addi_pc", out_pc, 32'h100);

      // back-pressure: fill, hold a third, then drain in order
      step(1'b1, 32'h00A00113, 32'h104, 1'b0, 1'b0);
      chk("bp_occupancy", occupancy, 2'd2);
      chk("bp_in_ready", in_ready, 1'b0);
      step(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0);
      chk("bp_held_occ", occupancy, 2'd2);
      step(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0);
      chk("bp_order1_pc", out_pc, 32'h104);
      step(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0);
      chk("bp_order2_pc", out_pc, 32'h108);
      drain();

      // flush with full queue and with a same-cycle input
      step(1'b1, 32'h00100213, 32'h200, 1'b0, 1'b0);
      step(1'b1, 32'h00200213, 32'h204, 1'b0, 1'b0);
      step(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b1);
      chk("flush_occ", occupancy, 2'd0);
      chk("flush_valid", out_valid, 1'b0);
      step(1'b1, 32'h00400213, 32'h20C, 1'b0, 1'b0);
      step(1'b1, 32'h00500213, 32'h210, 1'b1, 1'b1);
      chk("flush_in_occ", occupancy, 2'd0);

      // illegal / x0 cases
      probe(32'h0000007F);
      chk("unk_illegal", out_illegal, 1'b1);
      chk("unk_en", {out_code.alu.en, out_code.lsu.en, out_code.branch.en, out_code.rd_en}, 4'b0);
      drain();
      probe(32'h00000013);
      chk("nop_rd_en", out_code.rd_en, 1'b0);
      chk("nop_illegal", out_illegal, 1'b0);
      drain();
      probe(32'h40001033);
      chk("f7_20_sll_illegal", out_illegal, 1'b1);
      drain();
      probe(32'h022080B3);
`ifdef DECODE_RV32M_EN
      chk("mul_illegal", out_illegal, 1'b0);
      chk("mul_funct", out_code.alu.funct, ALU_MUL);
      chk("mul_rd_en", out_code.rd_en, 1'b1);
`else
      chk("mul_illegal", out_illegal, 1'b1);
      chk("mul_rd_en", out_code.rd_en, 1'b0);
`endif
      drain();

      // reset while entries are queued drops them
      step(1'b1, 32'h00100293, 32'h400, 1'b0, 1'b0);
      step(1'b1, 32'h00200293, 32'h404, 1'b0, 1'b0);
      rst = 1'b1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      mq.delete();
      #1;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst_occ", occupancy, 2'd0);
      chk("midrst_valid", out_valid, 1'b0);
      @(posedge clk); #1;

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      end
      repeat (3) drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
